// File: rtl/ysyx_23060208_axi_rd_arbiter_if.sv
// ysyx_23060208_axi_rd_arbiter_if: one AXI4 read-channel port (AR + R) with packed bundles.
// ar_bus = {araddr, arlen[7:0], arid[3:0], arsize[2:0], arburst[1:0]}, r_bus = {rdata, rresp[1:0], rlast, rid[3:0]}.
interface ysyx_23060208_axi_rd_arbiter_if #(parameter int DATA_WIDTH = 32);
    localparam int AR_BUS_W = DATA_WIDTH + 17;
    localparam int R_BUS_W = DATA_WIDTH * 2 + 7;
    logic arvalid;
    logic arready;
    logic [AR_BUS_W-1:0] ar_bus;
    logic rvalid;
    logic rready;
    logic [R_BUS_W-1:0] r_bus;
    modport master (output arvalid, ar_bus, rready, input arready, rvalid, r_bus);
    modport slave (input arvalid, ar_bus, rready, output arready, rvalid, r_bus);
endinterface

// File: rtl/ysyx_23060208_axi_rd_arbiter.sv
// ysyx_23060208_axi_rd_arbiter: IFU (m0) / LSU (m1) read arbiter onto one AXI4 slave, grant held AR through rlast.
// Define YSYX_23060208_ARB_RR_EN for round-robin on ties; otherwise the LSU always wins a tie.
module ysyx_23060208_axi_rd_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    ysyx_23060208_axi_rd_arbiter_if.slave       m0,
    ysyx_23060208_axi_rd_arbiter_if.slave       m1,
    ysyx_23060208_axi_rd_arbiter_if.master      s,
    output logic [1:0]                          grant,
    output logic                                busy
);
    localparam int AR_BUS_W = DATA_WIDTH + 17;
    localparam int R_BUS_W = DATA_WIDTH * 2 + 7;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state;
    logic pick_m1, in_addr, in_data, r_done;
`ifdef YSYX_23060208_ARB_RR_EN
    logic last_grant;
    assign pick_m1 = (m0.arvalid & m1.arvalid) ? ~last_grant : m1.arvalid;
    always_ff @(posedge clock)
        if (reset) last_grant <= 1'b1;
        else if (state == IDLE && (m0.arvalid | m1.arvalid)) last_grant <= pick_m1;
`else
    assign pick_m1 = m1.arvalid;
`endif
    assign in_addr = state == ADDR;
    assign in_data = state == DATA;
    assign busy = state != IDLE;
    assign r_done = s.rvalid & s.rready & s.r_bus[4];
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            grant <= 2'b00;
        end else if (state == IDLE) begin
            if (m0.arvalid | m1.arvalid) begin
                state <= ADDR;
                grant <= pick_m1 ? 2'b10 : 2'b01;
            end
        end else if (in_addr) begin
            if (s.arvalid & s.arready) state <= DATA;
        end else if (r_done) begin
            state <= IDLE;
            grant <= 2'b00;
        end
    end
    // Routing follows the registered grant only; rid is never inspected.
    assign s.arvalid = in_addr & (grant[1] ? m1.arvalid : m0.arvalid);
    assign s.ar_bus = grant[1] ? m1.ar_bus[AR_BUS_W-1:0] : m0.ar_bus[AR_BUS_W-1:0];
    assign m0.arready = in_addr & grant[0] & s.arready;
    assign m1.arready = in_addr & grant[1] & s.arready;
    assign s.rready = in_data & (grant[1] ? m1.rready : m0.rready);
    assign m0.rvalid = in_data & grant[0] & s.rvalid;
    assign m1.rvalid = in_data & grant[1] & s.rvalid;
    assign m0.r_bus = s.r_bus[R_BUS_W-1:0];
    assign m1.r_bus = s.r_bus[R_BUS_W-1:0];
endmodule

// File: tb/tb_ysyx_23060208_axi_rd_arbiter.sv
// tb_ysyx_23060208_axi_rd_arbiter: directed scenarios plus randomized masters/slave against a transaction-level model.
module tb_ysyx_23060208_axi_rd_arbiter;
    localparam int DW = 32;
    localparam int ARW = DW + 17;
    localparam int RW = DW * 2 + 7;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [1:0] grant;
    logic busy;
    ysyx_23060208_axi_rd_arbiter_if #(.DATA_WIDTH(DW)) m0_if();
    ysyx_23060208_axi_rd_arbiter_if #(.DATA_WIDTH(DW)) m1_if();
    ysyx_23060208_axi_rd_arbiter_if #(.DATA_WIDTH(DW)) s_if();
    ysyx_23060208_axi_rd_arbiter #(.DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .m0(m0_if), .m1(m1_if), .s(s_if), .grant(grant), .busy(busy)
    );
    always #5 clock = ~clock;

    logic m_arvalid [2];
    logic [ARW-1:0] m_ar_bus [2];
    logic m_rready [2];
    logic s_arready, s_rvalid;
    logic [RW-1:0] s_r_bus;
    logic d_arready [2];
    logic d_rvalid [2];
    logic [RW-1:0] d_r_bus [2];
    assign m0_if.arvalid = m_arvalid[0];
    assign m0_if.ar_bus = m_ar_bus[0];
    assign m0_if.rready = m_rready[0];
    assign m1_if.arvalid = m_arvalid[1];
    assign m1_if.ar_bus = m_ar_bus[1];
    assign m1_if.rready = m_rready[1];
    assign s_if.arready = s_arready;
    assign s_if.rvalid = s_rvalid;
    assign s_if.r_bus = s_r_bus;
    assign d_arready[0] = m0_if.arready;
    assign d_arready[1] = m1_if.arready;
    assign d_rvalid[0] = m0_if.rvalid;
    assign d_rvalid[1] = m1_if.rvalid;
    assign d_r_bus[0] = m0_if.r_bus;
    assign d_r_bus[1] = m1_if.r_bus;

    int checks = 0;
    int errors = 0;
    // model: owner 0 = none, 1 = IFU, 2 = LSU; end of transaction by beat count from arlen
    int mo = 0;
    bit mar_ok = 0;
    int mbeats = 0;
    bit mlast = 1;
    bit hs_mar [2];
    bit hs_mr [2];
    bit hs_sar, hs_sr;
    logic [ARW-1:0] cap_ar;
    logic [RW-1:0] cap_r;
    bit busy_m [2];
    int s_left;
    logic [3:0] s_id;
    int fwd;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ARW-1:0] mk_ar(input logic [31:0] a, input logic [7:0] len);
        return {a, len, 4'h1, 3'd2, 2'd1};
    endfunction

    task automatic mid();
        int g;
        bit addr, data;
        #3;
        g = (mo == 2) ? 1 : 0;
        addr = mo != 0 && !mar_ok;
        data = mo != 0 && mar_ok;
        chk("grant", grant, mo == 2 ? 2'b10 : mo == 1 ? 2'b01 : 2'b00);
        chk("busy", busy, mo != 0);
        chk("s_arvalid", s_if.arvalid, addr && m_arvalid[g]);
        if (addr && m_arvalid[g]) chk("s_ar_bus", s_if.ar_bus, m_ar_bus[g]);
        chk("s_rready", s_if.rready, data && m_rready[g]);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d_arready", i), d_arready[i], addr && mo == i + 1 && s_arready);
            chk($sformatf("m%0d_rvalid", i), d_rvalid[i], data && mo == i + 1 && s_rvalid);
            chk($sformatf("m%0d_r_bus", i), d_r_bus[i], s_r_bus);
            hs_mar[i] = m_arvalid[i] && d_arready[i];
            hs_mr[i] = d_rvalid[i] && m_rready[i];
        end
        hs_sar = s_if.arvalid && s_arready;
        hs_sr = s_rvalid && s_if.rready;
        cap_ar = s_if.ar_bus;
        cap_r = s_r_bus;
    endtask

    task automatic fin();
        int g;
        g = (mo == 2) ? 1 : 0;
        if (reset) begin
            mo = 0;
            mar_ok = 0;
            mlast = 1;
        end else if (mo == 0) begin
            if (m_arvalid[0] || m_arvalid[1]) begin
`ifdef YSYX_23060208_ARB_RR_EN
                mo = (m_arvalid[0] && m_arvalid[1]) ? (mlast ? 1 : 2) : (m_arvalid[1] ? 2 : 1);
`else
                mo = m_arvalid[1] ? 2 : 1;
`endif
                mlast = mo == 2;
                mar_ok = 0;
            end
        end else if (!mar_ok) begin
            if (m_arvalid[g] && s_arready) begin
                mar_ok = 1;
                mbeats = int'(m_ar_bus[g][16:9]) + 1;
            end
        end else if (s_rvalid && m_rready[g]) begin
            mbeats--;
            if (mbeats == 0) mo = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clear();
        for (int i = 0; i < 2; i++) begin
            m_arvalid[i] = 0;
            m_ar_bus[i] = '0;
            m_rready[i] = 0;
            busy_m[i] = 0;
            hs_mar[i] = 0;
            hs_mr[i] = 0;
        end
        s_arready = 0;
        s_rvalid = 0;
        s_r_bus = '0;
        s_left = 0;
        s_id = '0;
        hs_sar = 0;
        hs_sr = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear();
        mid();
        fin();
        reset = 0;
    endtask

    // entry: DUT in ADDR owned by master w; runs one single-beat read and the idle gap after it
    task automatic serve(input int w, input logic [1:0] resp, input bit again);
        s_arready = 1;
        mid();
        chk("serve_grant", grant, w == 1 ? 2'b10 : 2'b01);
        chk("serve_ar_bus", s_if.ar_bus, m_ar_bus[w]);
        chk("loser_arready", d_arready[1-w], 1'b0);
        fin();
        m_arvalid[w] = 0;
        s_arready = 0;
        s_rvalid = 1;
        s_r_bus = {32'hdead0000, 32'h00000013, resp, 1'b1, 4'h5};
        m_rready[0] = 1;
        m_rready[1] = 1;
        mid();
        chk("winner_rvalid", d_rvalid[w], 1'b1);
        chk("loser_rvalid", d_rvalid[1-w], 1'b0);
        chk("rresp", d_r_bus[w][6:5], resp);
        chk("rdata", d_r_bus[w][38:7], 32'h13);
        fin();
        s_rvalid = 0;
        if (again) m_arvalid[w] = 1;
        mid();
        chk("gap_busy", busy, 1'b0);
        chk("gap_grant", grant, 2'b00);
        fin();
    endtask

    task automatic agents();
        if (reset) begin
            clear();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (hs_mar[i]) begin
                m_arvalid[i] = 0;
                busy_m[i] = 1;
            end
            if (hs_mr[i] && cap_r[4]) busy_m[i] = 0;
            if (!m_arvalid[i] && !busy_m[i] && $urandom_range(3) == 0) begin
                m_arvalid[i] = 1;
                m_ar_bus[i] = mk_ar($urandom, 8'($urandom_range(3)));
            end
            m_rready[i] = $urandom_range(2) != 0;
        end
        if (hs_sar) begin
            s_left = int'(cap_ar[16:9]) + 1;
            s_id = cap_ar[8:5];
        end
        if (hs_sr) begin
            s_rvalid = 0;
            s_left--;
        end
        if (s_left > 0 && !s_rvalid && $urandom_range(2) != 0) begin
            s_rvalid = 1;
            s_r_bus = {$urandom, $urandom, 2'($urandom_range(3)), s_left == 1, s_id};
        end
        s_arready = 1'($urandom_range(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        clear();
        @(posedge clock);
        #1;
        do_reset();
        // single IFU read
        m_arvalid[0] = 1;
        m_ar_bus[0] = mk_ar(32'h8000_0000, 8'd0);
        mid();
        chk("req_cycle_grant", grant, 2'b00);
        chk("req_cycle_s_arvalid", s_if.arvalid, 1'b0);
        fin();
        serve(0, 2'b00, 0);
        // simultaneous request
        do_reset();
        m_arvalid[0] = 1;
        m_arvalid[1] = 1;
        m_ar_bus[0] = mk_ar(32'h8000_0100, 8'd0);
        m_ar_bus[1] = mk_ar(32'h8000_0200, 8'd0);
        mid();
        fin();
`ifdef YSYX_23060208_ARB_RR_EN
        serve(0, 2'b00, 1);
        serve(1, 2'b00, 1);
        serve(0, 2'b00, 0);
`else
        serve(1, 2'b00, 0);
        serve(0, 2'b00, 0);
`endif
        // slave error on IFU with LSU pending
        do_reset();
        m_arvalid[0] = 1;
        m_ar_bus[0] = mk_ar(32'h8000_0300, 8'd0);
        mid();
        fin();
        m_arvalid[1] = 1;
        m_ar_bus[1] = mk_ar(32'h8000_0400, 8'd0);
        serve(0, 2'b10, 0);
        serve(1, 2'b00, 0);
        // LSU burst of 4 with slave gaps and LSU backpressure on beat 2
        do_reset();
        m_arvalid[1] = 1;
        m_ar_bus[1] = mk_ar(32'h8000_0500, 8'd3);
        mid();
        fin();
        s_arready = 1;
        mid();
        fin();
        m_arvalid[1] = 0;
        s_arready = 0;
        fwd = 0;
        for (int c = 0, beats = 0; c < 30 && beats < 4; c++) begin
            if (!s_rvalid && c % 3 != 1) begin
                s_rvalid = 1;
                s_r_bus = {32'h0, 32'(beats), 2'b00, beats == 3, 4'h2};
            end
            m_rready[1] = !(beats == 1 && c < 6);
            mid();
            chk("burst_s_rready", s_if.rready, m_rready[1]);
            if (d_rvalid[1] && m_rready[1]) fwd++;
            if (s_rvalid && m_rready[1]) beats++;
            fin();
            if (hs_sr) s_rvalid = 0;
        end
        mid();
        chk("burst_beats", fwd, 4);
        chk("burst_released", busy, 1'b0);
        fin();
        // reset in DATA mid-burst
        do_reset();
        m_arvalid[1] = 1;
        m_ar_bus[1] = mk_ar(32'h8000_0600, 8'd3);
        mid();
        fin();
        s_arready = 1;
        mid();
        fin();
        m_arvalid[1] = 0;
        s_arready = 0;
        s_rvalid = 1;
        s_r_bus = {64'h1, 2'b00, 1'b0, 4'h3};
        m_rready[1] = 1;
        mid();
        fin();
        reset = 1;
        mid();
        fin();
        reset = 0;
        clear();
        mid();
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_s_arvalid", s_if.arvalid, 1'b0);
        chk("rst_s_rready", s_if.rready, 1'b0);
        chk("rst_m1_rvalid", d_rvalid[1], 1'b0);
        chk("rst_m0_arready", d_arready[0], 1'b0);
        fin();
        m_arvalid[0] = 1;
        m_ar_bus[0] = mk_ar(32'h8000_0700, 8'd0);
        mid();
        fin();
        serve(0, 2'b01, 0);
        // randomized traffic
        clear();
        for (int n = 0; n < 3000; n++) begin
            agents();
            reset = $urandom_range(599) == 0;
            mid();
            fin();
        end
        reset = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_23060208_axi_rd_arbiter.md
Name: ysyx_23060208_axi_rd_arbiter

Overview:
- Two-master, one-slave AXI4 read-channel arbiter.
- Shares the single instruction/data SRAM read port between the IFU (master 0) and the LSU (master 1).
- Locks the grant for a whole transaction (AR handshake through the R beat carrying rlast), then re-arbitrates.
- Only one read is outstanding at a time. Write channels do not pass through this block.

Parameters:
- DATA_WIDTH, 32: address width; read data is DATA_WIDTH*2 bits.
- AR_BUS_W, DATA_WIDTH+17: packed AR bundle {araddr, arlen[7:0], arid[3:0], arsize[2:0], arburst[1:0]}.
- R_BUS_W, DATA_WIDTH*2+7: packed R bundle {rdata, rresp[1:0], rlast, rid[3:0]}.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_arvalid  in  1  IFU read request valid
- m0_arready  out  1  IFU AR handshake ready
- m0_ar_bus  in  AR_BUS_W  IFU AR bundle
- m0_rvalid  out  1  IFU R beat valid
- m0_rready  in  1  IFU R ready
- m0_r_bus  out  R_BUS_W  IFU R bundle
- m1_arvalid / m1_arready / m1_ar_bus / m1_rvalid / m1_rready / m1_r_bus: LSU equivalents, same widths and directions
- s_arvalid  out  1  slave AR valid
- s_arready  in  1  slave AR ready
- s_ar_bus  out  AR_BUS_W  slave AR bundle
- s_rvalid  in  1  slave R valid
- s_rready  out  1  slave R ready
- s_r_bus  in  R_BUS_W  slave R bundle
- grant  out  2  one-hot current owner: bit0 = IFU, bit1 = LSU; 0 when idle
- busy  out  1  transaction in progress (state != IDLE)

Behaviour:
- One clock domain; reset is synchronous and active-high, ports named clock and reset.
- Reset values: state=IDLE, grant=2'b00, busy=0, s_arvalid=0, s_rready=0, m0/m1_arready=0, m0/m1_rvalid=0.
- Reset mid-transaction aborts immediately to IDLE. The slave is reset in the same cycle.
- State machine has three states: IDLE, ADDR, DATA.
- IDLE:
  - If any mN_arvalid is high, register the winner into grant and go to ADDR.
  - Otherwise stay in IDLE.
  - No slave signals are asserted in IDLE; arbitration costs exactly one cycle.
- ADDR (combinational pass-through for the granted master g):
  - s_arvalid = mg_arvalid, s_ar_bus = mg_ar_bus, mg_arready = s_arready.
  - s_arvalid & s_arready -> DATA.
  - The non-granted master sees arready=0.
  - If the granted master drops arvalid before the handshake (AXI violation), stay in ADDR; this case is not checked.
- DATA:
  - mg_rvalid = s_rvalid, s_rready = mg_rready, s_r_bus is routed to mg_r_bus.
  - Non-granted rvalid=0.
  - Handshake with rlast=1 -> IDLE and grant cleared.
  - Handshake with rlast=0 -> stay in DATA (bursts of arlen+1 beats).
- Both mN_r_bus outputs carry s_r_bus unconditionally; only rvalid is gated.
- rresp and rid pass through unmodified; an error response still terminates on rlast.
- Routing is by grant, not by rid.
- Default arbitration is fixed priority: LSU (m1) beats IFU (m0) on a simultaneous request.
- A request arriving in the cycle the last beat completes is seen in the following IDLE cycle. The minimum gap between transactions is one cycle.
- A request arriving during a transaction waits; it is never dropped while held.

Optional Feature:
- Macro: YSYX_23060208_ARB_RR_EN.
- Defined:
  - Round-robin arbitration on ties. A 1-bit last_grant register updates on every IDLE->ADDR transition.
  - On a tie the master not in last_grant wins.
  - last_grant resets to 1 (LSU), so the first tie goes to the IFU.
- Undefined: fixed LSU priority, and no last_grant register exists.

Test Plan:
- Single IFU read: m0_arvalid=1, araddr=0x8000_0000, arlen=0; slave returns rdata=0x...0013, rlast=1.
  -> grant=01 one cycle after the request; s_ar_bus matches m0; m0_rvalid pulses once; state back to IDLE; m1_rvalid=0 throughout.
- Simultaneous request, both arvalid=1 in the same cycle, macro undefined.
  -> LSU is served first (grant=10); IFU is then served after one idle cycle (grant=01); IFU arready stays 0 during the LSU transaction.
- Same stimulus with YSYX_23060208_ARB_RR_EN defined, three back-to-back tie rounds.
  -> Grant order is IFU, LSU, IFU.
- Burst: LSU arlen=3, slave inserts s_rvalid gaps and the LSU deasserts rready on beat 2.
  -> Exactly 4 beats are forwarded, backpressure reaches s_rready, and release happens only after the rlast handshake.
- Slave error: rresp=2'b10 with rlast=1 on an IFU read.
  -> m0_r_bus rresp=2'b10, the transaction completes, and a pending LSU request is granted next.
- Reset asserted in DATA mid-burst.
  -> The next cycle shows grant=00, busy=0, and all valid/ready outputs at 0; a fresh request then proceeds normally.
